// File: rtl/array_pair_loader.sv
// Serial-to-parallel loader that assembles two 2x2 operand arrays (A then B) from a word stream.
// Latency: OUT_VALID rises 1 cycle after the accept of the 8th word (the one carrying DIN_LAST).
// Backpressure: DIN_READY is low for the whole HOLD state, including the handoff cycle in which OUT_READY is seen.
//
// Ports:
//   CLK, RST                      rising-edge clock, synchronous active-high reset
//   DIN, DIN_VALID, DIN_LAST      input word stream; DIN_LAST marks the final word of a frame
//   DIN_READY                     loader can accept a word this cycle
//   A_OUT, B_OUT                  assembled arrays, packed as [row][col][NBITS-1:0]
//   OUT_VALID, OUT_READY          frame handshake towards the array compute stage
//   FRAME_ERR                     one-cycle pulse on a short or long frame
//   FRAME_CNT                     count of delivered frames, wraps modulo 2^CNT_BITS
module array_pair_loader #(
  parameter int NBITS    = 16,
  parameter int CNT_BITS = 8
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic [NBITS-1:0]                DIN,
  input  logic                            DIN_VALID,
  input  logic                            DIN_LAST,
  output logic                            DIN_READY,
  output logic [1:0][1:0][NBITS-1:0]      A_OUT,
  output logic [1:0][1:0][NBITS-1:0]      B_OUT,
  output logic                            OUT_VALID,
  input  logic                            OUT_READY,
  output logic                            FRAME_ERR,
  output logic [CNT_BITS-1:0]             FRAME_CNT
);

  typedef enum logic {FILL, HOLD} state_t;

  state_t     state, state_nxt;
  logic [2:0] idx, idx_nxt;
  logic       store;     // write DIN into the element addressed by idx
  logic       err_nxt;   // framing error detected on this accept
  logic       cnt_inc;   // frame handed to the consumer this cycle

  // State and control registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= FILL;
      idx       <= 3'd0;
      FRAME_ERR <= 1'b0;
      FRAME_CNT <= '0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      FRAME_ERR <= err_nxt;
      if (cnt_inc) begin
        FRAME_CNT <= FRAME_CNT + 1'b1;
      end
    end
  end

  // Next-state, handshake outputs and framing checks.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    DIN_READY = 1'b0;
    OUT_VALID = 1'b0;
    store     = 1'b0;
    err_nxt   = 1'b0;
    cnt_inc   = 1'b0;
    case (state)
      FILL: begin
        DIN_READY = 1'b1;
        if (DIN_VALID) begin
          if (idx == 3'd7) begin
            idx_nxt = 3'd0;
            if (DIN_LAST) begin
              store     = 1'b1;
              state_nxt = HOLD;
            end else begin
              // Long frame: the 8th word is dropped and the next word restarts at A[0][0].
              err_nxt = 1'b1;
            end
          end else if (DIN_LAST) begin
            // Short frame: drop the word; elements already written are left as they are.
            idx_nxt = 3'd0;
            err_nxt = 1'b1;
          end else begin
            store   = 1'b1;
            idx_nxt = idx + 3'd1;
          end
        end
      end
      HOLD: begin
        // No refill in the handoff cycle, so the arrays stay stable until OUT_VALID drops.
        OUT_VALID = 1'b1;
        if (OUT_READY) begin
          state_nxt = FILL;
          cnt_inc   = 1'b1;
        end
      end
    endcase
  end

  // Arrays are written in place: idx[2] selects A/B, idx[1] the row, idx[0] the column.
  always_ff @(posedge CLK) begin
    if (RST) begin
      A_OUT <= '0;
      B_OUT <= '0;
    end else if (store) begin
      if (!idx[2]) begin
        A_OUT[idx[1]][idx[0]] <= DIN;
      end else begin
        B_OUT[idx[1]][idx[0]] <= DIN;
      end
    end
  end

endmodule

// File: tb/tb_array_pair_loader.sv
// Directed bench for array_pair_loader: reset, clean/short/long/gapped frames, HOLD stall, reset mid-frame and in HOLD, counter wrap.
// Inputs are driven 1 time unit after each rising edge; outputs are checked at the same point.
// Arrays are compared as 64-bit packed words {[1][1],[1][0],[0][1],[0][0]}.
module tb_array_pair_loader;

  logic                 CLK;
  logic                 RST;
  logic [15:0]          DIN;
  logic                 DIN_VALID;
  logic                 DIN_LAST;
  logic                 DIN_READY;
  logic [1:0][1:0][15:0] A_OUT;
  logic [1:0][1:0][15:0] B_OUT;
  logic                 OUT_VALID;
  logic                 OUT_READY;
  logic                 FRAME_ERR;
  logic [7:0]           FRAME_CNT;

  int   checks;
  int   errors;
  int   got;
  int   cyc;
  logic early;
  logic v;

  array_pair_loader #(.NBITS(16), .CNT_BITS(8)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .DIN       (DIN),
    .DIN_VALID (DIN_VALID),
    .DIN_LAST  (DIN_LAST),
    .DIN_READY (DIN_READY),
    .A_OUT     (A_OUT),
    .B_OUT     (B_OUT),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .FRAME_ERR (FRAME_ERR),
    .FRAME_CNT (FRAME_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [63:0] pk(input int e00, input int e01, input int e10, input int e11);
    return {16'(e11), 16'(e10), 16'(e01), 16'(e00)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_word(input logic [15:0] d, input logic l);
    DIN       = d;
    DIN_LAST  = l;
    DIN_VALID = 1'b1;
    step();
    DIN_VALID = 1'b0;
    DIN_LAST  = 1'b0;
  endtask

  task automatic send_frame(input int base);
    for (int i = 0; i < 8; i++) begin
      send_word(16'(base + i), i == 7);
    end
  endtask

  task automatic release_frame();
    OUT_READY = 1'b1;
    step();
    OUT_READY = 1'b0;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    RST       = 1'b1;
    DIN       = 16'h0;
    DIN_VALID = 1'b0;
    DIN_LAST  = 1'b0;
    OUT_READY = 1'b0;
    step();
    step();
    RST = 1'b0;

    // Reset state
    chk("rst_out_valid", 64'(OUT_VALID), 64'd0);
    chk("rst_din_ready", 64'(DIN_READY), 64'd1);
    chk("rst_frame_err", 64'(FRAME_ERR), 64'd0);
    chk("rst_frame_cnt", 64'(FRAME_CNT), 64'd0);
    chk("rst_a", A_OUT, 64'd0);
    chk("rst_b", B_OUT, 64'd0);

    // Clean frame 1..8, with latency check around the last word
    for (int i = 1; i <= 7; i++) begin
      send_word(16'(i), 1'b0);
    end
    chk("f1_not_valid_before_last", 64'(OUT_VALID), 64'd0);
    send_word(16'd8, 1'b1);
    chk("f1_out_valid", 64'(OUT_VALID), 64'd1);
    chk("f1_din_ready", 64'(DIN_READY), 64'd0);
    chk("f1_a", A_OUT, pk(1, 2, 3, 4));
    chk("f1_b", B_OUT, pk(5, 6, 7, 8));

    // Stall in HOLD with junk on the input
    DIN       = 16'hFFFF;
    DIN_VALID = 1'b1;
    repeat (10) step();
    chk("hold_a", A_OUT, pk(1, 2, 3, 4));
    chk("hold_b", B_OUT, pk(5, 6, 7, 8));
    chk("hold_cnt", 64'(FRAME_CNT), 64'd0);
    chk("hold_valid", 64'(OUT_VALID), 64'd1);
    release_frame();
    DIN_VALID = 1'b0;
    chk("rel_cnt", 64'(FRAME_CNT), 64'd1);
    chk("rel_valid", 64'(OUT_VALID), 64'd0);
    chk("rel_din_ready", 64'(DIN_READY), 64'd1);
    chk("rel_no_refill", A_OUT, pk(1, 2, 3, 4));

    // Short frame: 3 words, third carries DIN_LAST
    send_word(16'd20, 1'b0);
    send_word(16'd21, 1'b0);
    chk("short_no_err_yet", 64'(FRAME_ERR), 64'd0);
    send_word(16'd22, 1'b1);
    chk("short_err", 64'(FRAME_ERR), 64'd1);
    chk("short_partial_a", A_OUT, pk(20, 21, 3, 4));
    chk("short_valid", 64'(OUT_VALID), 64'd0);
    step();
    chk("short_err_pulse", 64'(FRAME_ERR), 64'd0);
    send_frame(9);
    chk("f2_valid", 64'(OUT_VALID), 64'd1);
    chk("f2_a", A_OUT, pk(9, 10, 11, 12));
    chk("f2_b", B_OUT, pk(13, 14, 15, 16));
    release_frame();
    chk("f2_cnt", 64'(FRAME_CNT), 64'd2);

    // Long frame 30..37 without DIN_LAST, then a 1-word short frame back to back
    for (int i = 0; i < 8; i++) begin
      send_word(16'(30 + i), 1'b0);
    end
    chk("long_err", 64'(FRAME_ERR), 64'd1);
    chk("long_valid", 64'(OUT_VALID), 64'd0);
    chk("long_b", B_OUT, pk(34, 35, 36, 16));
    send_word(16'd40, 1'b1);
    chk("consec_err", 64'(FRAME_ERR), 64'd1);
    chk("consec_a", A_OUT, pk(30, 31, 32, 33));
    step();
    chk("consec_err_end", 64'(FRAME_ERR), 64'd0);
    send_frame(50);
    chk("f3_a", A_OUT, pk(50, 51, 52, 53));
    chk("f3_b", B_OUT, pk(54, 55, 56, 57));
    release_frame();
    chk("f3_cnt", 64'(FRAME_CNT), 64'd3);

    // Gapped frame 100..107 with random DIN_VALID
    got   = 0;
    cyc   = 0;
    early = 1'b0;
    while (got < 8 && cyc < 300) begin
      DIN       = 16'(100 + got);
      DIN_LAST  = (got == 7);
      v         = 1'($urandom_range(0, 1));
      DIN_VALID = v;
      if (OUT_VALID) early = 1'b1;
      step();
      cyc++;
      if (v) got++;
    end
    DIN_VALID = 1'b0;
    DIN_LAST  = 1'b0;
    chk("gap_accepts", 64'(got), 64'd8);
    chk("gap_no_early_valid", 64'(early), 64'd0);
    chk("gap_latency", 64'(OUT_VALID), 64'd1);
    chk("gap_a", A_OUT, pk(100, 101, 102, 103));
    chk("gap_b", B_OUT, pk(104, 105, 106, 107));
    release_frame();
    chk("gap_cnt", 64'(FRAME_CNT), 64'd4);

    // Reset after 5 words of a frame
    for (int i = 0; i < 5; i++) begin
      send_word(16'(60 + i), 1'b0);
    end
    RST = 1'b1;
    step();
    RST = 1'b0;
    chk("rst_mid_a", A_OUT, 64'd0);
    chk("rst_mid_b", B_OUT, 64'd0);
    chk("rst_mid_err", 64'(FRAME_ERR), 64'd0);
    chk("rst_mid_cnt", 64'(FRAME_CNT), 64'd0);
    chk("rst_mid_ready", 64'(DIN_READY), 64'd1);
    send_frame(70);
    chk("post_rst_a", A_OUT, pk(70, 71, 72, 73));
    chk("post_rst_b", B_OUT, pk(74, 75, 76, 77));

    // Reset while in HOLD
    RST = 1'b1;
    step();
    RST = 1'b0;
    chk("rst_hold_valid", 64'(OUT_VALID), 64'd0);
    chk("rst_hold_ready", 64'(DIN_READY), 64'd1);
    chk("rst_hold_a", A_OUT, 64'd0);
    chk("rst_hold_err", 64'(FRAME_ERR), 64'd0);

    // 256 delivered frames wrap the counter
    for (int k = 0; k < 256; k++) begin
      send_frame(k * 8);
      release_frame();
      if (k == 254) chk("cnt_255", 64'(FRAME_CNT), 64'd255);
    end
    chk("cnt_wrap", 64'(FRAME_CNT), 64'd0);
    chk("wrap_last_b", B_OUT, pk(2044, 2045, 2046, 2047));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
